// File: rtl/satd_pkg.sv
// Shared widths, FSM states and row types for the 4x8 Hadamard SATD block.
package satd_pkg;

    localparam int DIFF_W     = 9;
    localparam int ROWS       = 4;
    localparam int COLS       = 8;
    localparam int ROW_COEF_W = 12;
    localparam int COL_COEF_W = 14;
    localparam int ABS_W      = 13;
    localparam int SATD_W     = 18;
    localparam int SUM_W      = 16;  // eight 13-bit magnitudes per column cycle

    typedef enum logic [1:0] {
        ST_ROWS,
        ST_COLS,
        ST_OUT
    } satd_state_e;

    typedef logic [COLS-1:0][DIFF_W-1:0]     diff_row_t;
    typedef logic [COLS-1:0][ROW_COEF_W-1:0] coef_row_t;

    // Residuals are bounded to +/-255, so a column coefficient never exceeds 8160.
    function automatic logic [ABS_W-1:0] abs_coef(input logic signed [COL_COEF_W-1:0] v);
        logic signed [COL_COEF_W-1:0] m;
        m = (v < 0) ? -v : v;
        return m[ABS_W-1:0];
    endfunction

endpackage

// File: rtl/satd_had8.sv
// Combinational 8-point Hadamard: three sign-extending butterfly levels, 9-bit in, 12-bit out.
module satd_had8
    import satd_pkg::*;
(
    input  logic [COLS*DIFF_W-1:0]     diff_row,
    output logic [COLS*ROW_COEF_W-1:0] coef_row
);

    diff_row_t               d;
    coef_row_t               c;
    logic signed [9:0]       s1 [COLS];
    logic signed [10:0]      s2 [COLS];
    logic signed [11:0]      s3 [COLS];

    assign d        = diff_row_t'(diff_row);
    assign coef_row = c;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            s1[j]   = 10'($signed(d[j])) + 10'($signed(d[j+4]));
            s1[j+4] = 10'($signed(d[j])) - 10'($signed(d[j+4]));
        end
        for (int g = 0; g < COLS; g += 4) begin
            for (int j = 0; j < 2; j++) begin
                s2[g+j]   = 11'(s1[g+j]) + 11'(s1[g+j+2]);
                s2[g+j+2] = 11'(s1[g+j]) - 11'(s1[g+j+2]);
            end
        end
        for (int p = 0; p < 4; p++) begin
            s3[2*p]   = 12'(s2[2*p]) + 12'(s2[2*p+1]);
            s3[2*p+1] = 12'(s2[2*p]) - 12'(s2[2*p+1]);
        end
        for (int k = 0; k < COLS; k++) begin
            c[k] = s3[k];
        end
    end

endmodule

// File: rtl/satd_hadamard_acc.sv
// 4x8 SATD: row Hadamard into a transpose buffer, then two 4-point column Hadamards per cycle
// with abs/accumulate; one result per block over valid/ready.
module satd_hadamard_acc
    import satd_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COLS*DIFF_W-1:0] diff_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SATD_W-1:0]      satd
);

    satd_state_e                     state;
    logic [1:0]                      row_cnt;
    logic [1:0]                      col_cnt;
    logic [SATD_W-1:0]               acc;
    logic [COLS*ROW_COEF_W-1:0]      row_coef_flat;
    coef_row_t                       row_coef;
    logic signed [ROW_COEF_W-1:0]    buf_q [ROWS][COLS];
    logic [SUM_W-1:0]                col_sum;
    logic                            accept;

    assign in_ready = (state == ST_ROWS);
    assign accept   = in_valid && in_ready;
    assign row_coef = coef_row_t'(row_coef_flat);

    satd_had8 u_had8 (
        .diff_row (diff_row),
        .coef_row (row_coef_flat)
    );

    // NOTE: the transpose buffer has no reset; every row is rewritten before the column pass reads it.
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int k = 0; k < COLS; k++) begin
                buf_q[row_cnt][k] <= row_coef[k];
            end
        end
    end

    // NOTE: combinational temporaries use blocking '=' and get a value before any read, so no latch forms.
    always_comb begin : col_tree
        logic [2:0]                    col_idx;
        logic signed [COL_COEF_W-1:0]  r0, r1, r2, r3, t0, t1, t2, t3;
        col_sum = '0;
        col_idx = '0;
        for (int k = 0; k < 2; k++) begin
            col_idx = {col_cnt, 1'(k)};
            r0 = 14'(buf_q[0][col_idx]);
            r1 = 14'(buf_q[1][col_idx]);
            r2 = 14'(buf_q[2][col_idx]);
            r3 = 14'(buf_q[3][col_idx]);
            t0 = r0 + r1;
            t1 = r0 - r1;
            t2 = r2 + r3;
            t3 = r2 - r3;
            col_sum = col_sum + SUM_W'(abs_coef(t0 + t2)) + SUM_W'(abs_coef(t0 - t2))
                              + SUM_W'(abs_coef(t1 + t3)) + SUM_W'(abs_coef(t1 - t3));
        end
    end

    // NOTE: all registered state updates use non-blocking '<='.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_ROWS;
            row_cnt   <= '0;
            col_cnt   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            satd      <= '0;
        end else begin
            case (state)
                ST_ROWS: begin
                    if (accept) begin
                        row_cnt <= row_cnt + 2'd1;
                        if (row_cnt == 2'(ROWS - 1)) begin
                            state <= ST_COLS;
                        end
                    end
                end
                ST_COLS: begin
                    col_cnt <= col_cnt + 2'd1;
                    if (col_cnt == 2'd3) begin
                        satd      <= acc + SATD_W'(col_sum);
                        acc       <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else begin
                        acc <= acc + SATD_W'(col_sum);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ROWS;
                    end
                end
                default: state <= ST_ROWS;
            endcase
        end
    end

endmodule

// File: tb/tb_satd_hadamard_acc.sv
// Randomised and directed bench for satd_hadamard_acc against a matrix-product SATD model.
module tb_satd_hadamard_acc;

    typedef int mat_t [4][8];

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [71:0] diff_row = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] satd;

    int checks = 0;
    int errors = 0;

    satd_hadamard_acc dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff_row  (diff_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .satd      (satd)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // SATD straight from the definition: sum over |H4 * D * H8^T| with Sylvester signs.
    function automatic int ref_satd(input mat_t m);
        int sum;
        int c;
        sum = 0;
        for (int u = 0; u < 4; u++) begin
            for (int v = 0; v < 8; v++) begin
                c = 0;
                for (int r = 0; r < 4; r++) begin
                    for (int k = 0; k < 8; k++) begin
                        if ((($countones(u & r) + $countones(v & k)) % 2) == 1) c -= m[r][k];
                        else c += m[r][k];
                    end
                end
                sum += (c < 0) ? -c : c;
            end
        end
        return sum;
    endfunction

    function automatic logic [71:0] pack_row(input mat_t m, input int r);
        logic [71:0] p;
        for (int k = 0; k < 8; k++) p[9*k +: 9] = 9'(m[r][k]);
        return p;
    endfunction

    function automatic mat_t fill(input int v);
        mat_t m;
        for (int r = 0; r < 4; r++) for (int k = 0; k < 8; k++) m[r][k] = v;
        return m;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 8; k++) m[r][k] = int'($urandom_range(0, 510)) - 255;
        return m;
    endfunction

    task automatic send_rows(input mat_t m, input int nrows, input bit bubbles);
        int n;
        for (int r = 0; r < nrows; r++) begin
            if (bubbles && r > 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            diff_row = pack_row(m, r);
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            if (n == 50) check("in_ready_wait", 0, 1);
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic finish_block(input string tag, input int exp, input int hold);
        int lat;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_satd"}, int'(satd), exp);
        check({tag, "_in_ready_busy"}, int'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_satd"}, int'(satd), exp);
            check({tag, "_hold_valid"}, int'(out_valid), 1);
            check({tag, "_hold_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_cleared"}, int'(out_valid), 0);
        check({tag, "_in_ready_after"}, int'(in_ready), 1);
    endtask

    task automatic run_block(input string tag, input mat_t m, input int exp, input bit bubbles, input int hold);
        send_rows(m, 4, bubbles);
        finish_block(tag, exp, hold);
    endtask

    task automatic stream_test();
        logic [71:0] rowq[$];
        int          expq[$];
        int          prev_cycle;
        int          got;
        bit          ir;
        mat_t        m;
        m = fill(0);
        m[0][0] = 5;
        for (int r = 0; r < 4; r++) rowq.push_back(pack_row(m, r));
        expq.push_back(160);
        m = fill(0);
        for (int r = 0; r < 4; r++) rowq.push_back(pack_row(m, r));
        expq.push_back(0);
        for (int b = 0; b < 3; b++) begin
            m = rand_mat();
            for (int r = 0; r < 4; r++) rowq.push_back(pack_row(m, r));
            expq.push_back(ref_satd(m));
        end
        prev_cycle = -1;
        got = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && expq.size() > 0; cyc++) begin
            in_valid = (rowq.size() > 0);
            diff_row = (rowq.size() > 0) ? rowq[0] : '0;
            ir = in_ready;
            if (out_valid) begin
                check("stream_satd", int'(satd), expq.pop_front());
                if (prev_cycle >= 0) check("stream_period", cyc - prev_cycle, 9);
                prev_cycle = cyc;
                got++;
            end
            tick();
            if (ir && in_valid) void'(rowq.pop_front());
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("stream_results", got, 5);
    endtask

    initial begin
        mat_t m;
        int   pulses;

        tick();
        tick();
        RST = 1'b0;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_satd", int'(satd), 0);
        check("reset_in_ready", int'(in_ready), 1);

        run_block("zero", fill(0), 0, 1'b0, 0);
        run_block("plus1", fill(1), 32, 1'b0, 0);
        run_block("minus255", fill(-255), 8160, 1'b0, 0);
        m = fill(0);
        m[0][0] = 5;
        run_block("impulse", m, 160, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            m = rand_mat();
            run_block("random", m, ref_satd(m), 1'(i % 2), 0);
        end

        m = rand_mat();
        run_block("bubble_hold", m, ref_satd(m), 1'b1, 10);

        m = rand_mat();
        send_rows(m, 2, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_in_ready", int'(in_ready), 1);
        run_block("post_reset", fill(1), 32, 1'b0, 0);
        out_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        out_ready = 1'b0;
        check("post_reset_extra_pulses", pulses, 0);

        stream_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
